// File: rtl/mips_cpu_wb_arbiter_if.sv
// Bundle of execute/memory writeback requests, decode hazard queries and the regfile write port.
// The arbiter takes the slave side; the producer/consumer stages take the master side.
interface mips_cpu_wb_arbiter_if #(
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH + 1);

   logic          alu_valid;
   logic          alu_ready;
   logic [4:0]    alu_reg;
   logic [31:0]   alu_data;
   logic          load_valid;
   logic          load_ready;
   logic [4:0]    load_reg;
   logic [31:0]   load_data;
   logic [5:0]    load_opcode;
   logic [1:0]    load_addr_lo;
   logic          flush;
   logic [4:0]    q_reg1;
   logic [4:0]    q_reg2;
   logic          q_busy1;
   logic          q_busy2;
   logic          wb_regwrite;
   logic [4:0]    wb_writereg;
   logic [31:0]   wb_writedata;
   logic [5:0]    wb_opcode;
   logic [1:0]    wb_addr_lo;
   logic [CW-1:0] fifo_count;

   // Both offer paths use valid/ready: a transfer happens on the posedge where valid && ready,
   // valid may not depend on ready, and ready is computed from registered state plus the offered reg.
   modport slave (
      input  alu_valid, alu_reg, alu_data,
      input  load_valid, load_reg, load_data, load_opcode, load_addr_lo,
      input  flush, q_reg1, q_reg2,
      output alu_ready, load_ready, q_busy1, q_busy2,
      output wb_regwrite, wb_writereg, wb_writedata, wb_opcode, wb_addr_lo, fifo_count
   );

   modport master (
      output alu_valid, alu_reg, alu_data,
      output load_valid, load_reg, load_data, load_opcode, load_addr_lo,
      output flush, q_reg1, q_reg2,
      input  alu_ready, load_ready, q_busy1, q_busy2,
      input  wb_regwrite, wb_writereg, wb_writedata, wb_opcode, wb_addr_lo, fifo_count
   );
endinterface

// File: rtl/mips_cpu_wb_arbiter.sv
// Single regfile write port shared by load returns (priority) and ALU results (queued on loss),
// with a pending-write scoreboard for decode RAW stalls.
module mips_cpu_wb_arbiter #(
   parameter int DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   mips_cpu_wb_arbiter_if.slave bus
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DEPTH-1:0] r_valid;
   logic [4:0]       r_reg  [DEPTH];
   logic [31:0]      r_data [DEPTH];
   logic [AW-1:0]    r_wr;
   logic [AW-1:0]    r_rd;
   logic [CW-1:0]    r_count;

   logic        r_wb_regwrite;
   logic [4:0]  r_wb_writereg;
   logic [31:0] r_wb_writedata;
   logic [5:0]  r_wb_opcode;
   logic [1:0]  r_wb_addr_lo;

   logic w_hit_load, w_hit_q1, w_hit_q2;
   logic w_alu_ready, w_load_ready;
   logic w_load_take, w_pop, w_bypass, w_push;

   always_comb begin
      w_hit_load = 1'b0;
      w_hit_q1   = 1'b0;
      w_hit_q2   = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (r_valid[i] && r_reg[i] == bus.load_reg) w_hit_load = 1'b1;
         if (r_valid[i] && r_reg[i] == bus.q_reg1)   w_hit_q1   = 1'b1;
         if (r_valid[i] && r_reg[i] == bus.q_reg2)   w_hit_q2   = 1'b1;
      end
   end

   assign w_alu_ready  = (r_count < CW'(DEPTH));
   // A load must not overtake an older queued ALU write to the same register.
   assign w_load_ready = !(bus.load_reg != 5'd0 && w_hit_load);

   // Writes to r0 complete their handshake but never occupy the port or the FIFO.
   assign w_load_take = bus.load_valid && w_load_ready && (bus.load_reg != 5'd0);
   assign w_pop       = !w_load_take && (r_count != '0);
   assign w_bypass    = !w_load_take && (r_count == '0) && bus.alu_valid && (bus.alu_reg != 5'd0);
   assign w_push      = bus.alu_valid && w_alu_ready && (bus.alu_reg != 5'd0) && !w_bypass;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid        <= '0;
         r_wr           <= '0;
         r_rd           <= '0;
         r_count        <= '0;
         r_wb_regwrite  <= 1'b0;
         r_wb_writereg  <= '0;
         r_wb_writedata <= '0;
         r_wb_opcode    <= '0;
         r_wb_addr_lo   <= '0;
      end else if (bus.flush) begin
         r_valid        <= '0;
         r_wr           <= '0;
         r_rd           <= '0;
         r_count        <= '0;
         r_wb_regwrite  <= 1'b0;
         r_wb_writereg  <= '0;
         r_wb_writedata <= '0;
         r_wb_opcode    <= '0;
         r_wb_addr_lo   <= '0;
      end else begin
         if (w_push) begin
            r_valid[r_wr] <= 1'b1;
            r_wr          <= r_wr + AW'(1);
         end
         if (w_pop) begin
            r_valid[r_rd] <= 1'b0;
            r_rd          <= r_rd + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase

         r_wb_regwrite <= w_load_take || w_pop || w_bypass;
         if (w_load_take) begin
            r_wb_writereg  <= bus.load_reg;
            r_wb_writedata <= bus.load_data;
            r_wb_opcode    <= bus.load_opcode;
            r_wb_addr_lo   <= bus.load_addr_lo;
         end else if (w_pop) begin
            r_wb_writereg  <= r_reg[r_rd];
            r_wb_writedata <= r_data[r_rd];
            r_wb_opcode    <= 6'd0;
            r_wb_addr_lo   <= 2'd0;
         end else if (w_bypass) begin
            r_wb_writereg  <= bus.alu_reg;
            r_wb_writedata <= bus.alu_data;
            r_wb_opcode    <= 6'd0;
            r_wb_addr_lo   <= 2'd0;
         end else begin
            r_wb_writereg  <= '0;
            r_wb_writedata <= '0;
            r_wb_opcode    <= '0;
            r_wb_addr_lo   <= '0;
         end
      end
   end

   // Payload storage needs no reset; occupancy is tracked by r_valid.
   always_ff @(posedge clk) begin
      if (w_push && !bus.flush) begin
         r_reg[r_wr]  <= bus.alu_reg;
         r_data[r_wr] <= bus.alu_data;
      end
   end

   assign bus.alu_ready    = w_alu_ready;
   assign bus.load_ready   = w_load_ready;
   assign bus.q_busy1      = (bus.q_reg1 != 5'd0) &&
                             (w_hit_q1 || (r_wb_regwrite && r_wb_writereg == bus.q_reg1));
   assign bus.q_busy2      = (bus.q_reg2 != 5'd0) &&
                             (w_hit_q2 || (r_wb_regwrite && r_wb_writereg == bus.q_reg2));
   assign bus.wb_regwrite  = r_wb_regwrite;
   assign bus.wb_writereg  = r_wb_writereg;
   assign bus.wb_writedata = r_wb_writedata;
   assign bus.wb_opcode    = r_wb_opcode;
   assign bus.wb_addr_lo   = r_wb_addr_lo;
   assign bus.fifo_count   = r_count;
endmodule

// File: tb/tb_mips_cpu_wb_arbiter.sv
// Directed bench for the writeback arbiter: bypass, contention, fill/drain order,
// same-register load hold, scoreboard, r0, flush and asynchronous reset.
module tb_mips_cpu_wb_arbiter;
   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_bad;

   mips_cpu_wb_arbiter_if #(.DEPTH(4)) bus ();

   mips_cpu_wb_arbiter #(.DEPTH(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      bus.alu_valid    = 1'b0;
      bus.alu_reg      = 5'd0;
      bus.alu_data     = 32'd0;
      bus.load_valid   = 1'b0;
      bus.load_reg     = 5'd0;
      bus.load_data    = 32'd0;
      bus.load_opcode  = 6'd0;
      bus.load_addr_lo = 2'd0;
      bus.flush        = 1'b0;
   endtask

   task automatic offer_alu(input logic [4:0] r, input logic [31:0] d);
      bus.alu_valid = 1'b1;
      bus.alu_reg   = r;
      bus.alu_data  = d;
   endtask

   task automatic offer_load(input logic [4:0] r, input logic [31:0] d,
                             input logic [5:0] op, input logic [1:0] lo);
      bus.load_valid   = 1'b1;
      bus.load_reg     = r;
      bus.load_data    = d;
      bus.load_opcode  = op;
      bus.load_addr_lo = lo;
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      idle();
      bus.q_reg1 = 5'd0;
      bus.q_reg2 = 5'd0;
      rst_n = 1'b0;
      tick();
      tick();
      chk("rst_regwrite", 32'(bus.wb_regwrite), 32'd0);
      chk("rst_count",    32'(bus.fifo_count),  32'd0);
      chk("rst_data",     bus.wb_writedata,     32'd0);
      chk("rst_alu_rdy",  32'(bus.alu_ready),   32'd1);
      chk("rst_load_rdy", 32'(bus.load_ready),  32'd1);
      #2 rst_n = 1'b1;
      tick();

      // ALU only: direct bypass, nothing queued
      offer_alu(5'd8, 32'h11);
      tick();
      idle();
      chk("alu_regwrite", 32'(bus.wb_regwrite), 32'd1);
      chk("alu_reg",      32'(bus.wb_writereg), 32'd8);
      chk("alu_data",     bus.wb_writedata,     32'h11);
      chk("alu_opcode",   32'(bus.wb_opcode),   32'd0);
      chk("alu_count",    32'(bus.fifo_count),  32'd0);
      bus.q_reg1 = 5'd8;
      #1 chk("alu_busy_staged", 32'(bus.q_busy1), 32'd1);
      tick();
      chk("alu_idle", 32'(bus.wb_regwrite), 32'd0);
      chk("alu_busy_clear", 32'(bus.q_busy1), 32'd0);

      // Contention: load wins, ALU queued then drained
      offer_load(5'd9, 32'hAA, 6'h23, 2'd2);
      offer_alu(5'd10, 32'hBB);
      tick();
      idle();
      chk("cont1_reg",    32'(bus.wb_writereg), 32'd9);
      chk("cont1_data",   bus.wb_writedata,     32'hAA);
      chk("cont1_opcode", 32'(bus.wb_opcode),   32'h23);
      chk("cont1_lo",     32'(bus.wb_addr_lo),  32'd2);
      chk("cont1_count",  32'(bus.fifo_count),  32'd1);
      tick();
      chk("cont2_we",     32'(bus.wb_regwrite), 32'd1);
      chk("cont2_reg",    32'(bus.wb_writereg), 32'd10);
      chk("cont2_data",   bus.wb_writedata,     32'hBB);
      chk("cont2_opcode", 32'(bus.wb_opcode),   32'd0);
      chk("cont2_lo",     32'(bus.wb_addr_lo),  32'd0);
      chk("cont2_count",  32'(bus.fifo_count),  32'd0);
      tick();
      chk("cont_idle", 32'(bus.wb_regwrite), 32'd0);

      // Fill: loads hold the port while five ALU results are offered
      for (int i = 0; i < 5; i++) begin
         offer_load(5'(20 + i), 32'h200 + 32'(i), 6'h20, 2'd0);
         offer_alu(5'(11 + i), 32'h100 + 32'(i));
         #1 chk($sformatf("fill_rdy%0d", i), 32'(bus.alu_ready), (i < 4) ? 32'd1 : 32'd0);
         tick();
         chk($sformatf("fill_wreg%0d", i), 32'(bus.wb_writereg), 32'(20 + i));
         chk($sformatf("fill_cnt%0d", i), 32'(bus.fifo_count), (i < 4) ? 32'(i + 1) : 32'd4);
      end
      idle();
      for (int i = 0; i < 4; i++) begin
         tick();
         chk($sformatf("drain_reg%0d", i),  32'(bus.wb_writereg), 32'(11 + i));
         chk($sformatf("drain_data%0d", i), bus.wb_writedata,     32'h100 + 32'(i));
         chk($sformatf("drain_cnt%0d", i),  32'(bus.fifo_count),  32'(3 - i));
      end
      tick();
      chk("drain_idle", 32'(bus.wb_regwrite), 32'd0);

      // Same register: load to r5 held behind queued ALU write to r5
      offer_load(5'd30, 32'h300, 6'h23, 2'd0);
      offer_alu(5'd5, 32'h55);
      tick();
      idle();
      offer_load(5'd5, 32'h66, 6'h21, 2'd1);
      #1 chk("same_load_rdy0", 32'(bus.load_ready), 32'd0);
      chk("same_count", 32'(bus.fifo_count), 32'd1);
      tick();
      chk("same_first_reg",  32'(bus.wb_writereg), 32'd5);
      chk("same_first_data", bus.wb_writedata,     32'h55);
      chk("same_load_rdy1",  32'(bus.load_ready),  32'd1);
      tick();
      idle();
      chk("same_second_reg",  32'(bus.wb_writereg), 32'd5);
      chk("same_second_data", bus.wb_writedata,     32'h66);
      chk("same_second_op",   32'(bus.wb_opcode),   32'h21);
      tick();

      // Scoreboard: queued reg 7, staged reg 31
      offer_load(5'd31, 32'h31, 6'h23, 2'd0);
      offer_alu(5'd7, 32'h77);
      tick();
      idle();
      bus.q_reg1 = 5'd7;
      bus.q_reg2 = 5'd31;
      #1 chk("haz_q1_fifo",   32'(bus.q_busy1), 32'd1);
      chk("haz_q2_staged", 32'(bus.q_busy2), 32'd1);
      bus.q_reg2 = 5'd6;
      #1 chk("haz_q2_free", 32'(bus.q_busy2), 32'd0);
      tick();
      chk("haz_pop_reg",    32'(bus.wb_writereg), 32'd7);
      chk("haz_q1_staged",  32'(bus.q_busy1),     32'd1);
      tick();
      chk("haz_q1_clear",   32'(bus.q_busy1),     32'd0);
      bus.q_reg1 = 5'd0;

      // ALU write to r0: accepted, never written
      offer_alu(5'd0, 32'hDEAD);
      #1 chk("zero_rdy", 32'(bus.alu_ready), 32'd1);
      tick();
      idle();
      chk("zero_we",  32'(bus.wb_regwrite), 32'd0);
      chk("zero_cnt", 32'(bus.fifo_count),  32'd0);
      chk("zero_busy", 32'(bus.q_busy1),    32'd0);

      // Flush with three queued entries
      for (int i = 0; i < 3; i++) begin
         offer_load(5'(21 + i), 32'h400 + 32'(i), 6'h23, 2'd0);
         offer_alu(5'(1 + i), 32'h500 + 32'(i));
         tick();
      end
      idle();
      chk("flush_pre_cnt", 32'(bus.fifo_count), 32'd3);
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      chk("flush_cnt", 32'(bus.fifo_count),  32'd0);
      chk("flush_we",  32'(bus.wb_regwrite), 32'd0);
      tick();
      chk("flush_we2", 32'(bus.wb_regwrite), 32'd0);

      // Asynchronous reset with two queued entries
      for (int i = 0; i < 2; i++) begin
         offer_load(5'(25 + i), 32'h600 + 32'(i), 6'h23, 2'd0);
         offer_alu(5'(16 + i), 32'h700 + 32'(i));
         tick();
      end
      idle();
      chk("arst_pre_cnt", 32'(bus.fifo_count),  32'd2);
      chk("arst_pre_we",  32'(bus.wb_regwrite), 32'd1);
      #2 rst_n = 1'b0;
      #1 chk("arst_we",   32'(bus.wb_regwrite), 32'd0);
      chk("arst_cnt",  32'(bus.fifo_count),  32'd0);
      chk("arst_reg",  32'(bus.wb_writereg), 32'd0);
      chk("arst_data", bus.wb_writedata,     32'd0);
      tick();
      #2 rst_n = 1'b1;
      tick();
      chk("arst_post_we1", 32'(bus.wb_regwrite), 32'd0);
      tick();
      chk("arst_post_we2", 32'(bus.wb_regwrite), 32'd0);
      chk("arst_post_cnt", 32'(bus.fifo_count),  32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
